// File: rtl/rram_prog_pkg.sv
// Shared types for the RRAM configuration-cell programming sequencer:
// FSM states, local line indices and the (data, phase) -> line one-hot map.
package rram_prog_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PH0_ON,
    PH0_GAP,
    PH1_ON,
    PH1_GAP,
    ERR
  } prog_state_t;

  localparam logic [1:0] BL_R0_CLR = 2'd0;
  localparam logic [1:0] BL_R1_CLR = 2'd1;
  localparam logic [1:0] BL_SET    = 2'd2;
  localparam logic [1:0] WL_R0_SET = 2'd0;
  localparam logic [1:0] WL_R1_SET = 2'd1;
  localparam logic [1:0] WL_CLR    = 2'd2;

  typedef struct packed {
    logic [2:0] bl;
    logic [2:0] wl;
  } local_lines_t;

  // data=1 leaves r0=1,r1=0 and data=0 leaves r0=0,r1=1, so dout = r0 | ~r1 = data.
  function automatic local_lines_t phase_lines(input logic data, input logic phase);
    local_lines_t l;
    l = '0;
    case ({data, phase})
      2'b10: begin
        l.bl[BL_SET]    = 1'b1;
        l.wl[WL_R0_SET] = 1'b1;
      end
      2'b11: begin
        l.bl[BL_R1_CLR] = 1'b1;
        l.wl[WL_CLR]    = 1'b1;
      end
      2'b00: begin
        l.bl[BL_R0_CLR] = 1'b1;
        l.wl[WL_CLR]    = 1'b1;
      end
      default: begin
        l.bl[BL_SET]    = 1'b1;
        l.wl[WL_R1_SET] = 1'b1;
      end
    endcase
    return l;
  endfunction

endpackage

// File: rtl/rram_prog_ctrl_line_dec.sv
// Places one cell's local BL/WL one-hots at the addressed cell, zero elsewhere.
module rram_prog_line_dec #(
  parameter int NUM_CELLS = 8,
  parameter int ADDR_W    = 3
) (
  input  logic                   en,
  input  logic [ADDR_W-1:0]      addr,
  input  logic [2:0]             bl_loc,
  input  logic [2:0]             wl_loc,
  output logic [3*NUM_CELLS-1:0] bl,
  output logic [3*NUM_CELLS-1:0] wl
);

  always_comb begin
    bl = '0;
    wl = '0;
    for (int i = 0; i < NUM_CELLS; i++) begin
      if (en && (addr == ADDR_W'(i))) begin
        bl[3*i +: 3] = bl_loc;
        wl[3*i +: 3] = wl_loc;
      end
    end
  end

endmodule

// File: rtl/rram_prog_ctrl.sv
// Programs one 2-RRAM configuration cell per command with two timed BL/WL
// pulse phases; all lines, done, err and cmd_ready are registered.
module rram_prog_ctrl
  import rram_prog_pkg::*;
#(
  parameter int NUM_CELLS    = 8,
  parameter int ADDR_W       = 3,
  parameter int PULSE_CYCLES = 4,
  parameter int GAP_CYCLES   = 2,
  parameter int CNT_W        = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [ADDR_W-1:0]      cmd_addr,
  input  logic                   cmd_data,
  output logic [3*NUM_CELLS-1:0] bl,
  output logic [3*NUM_CELLS-1:0] wl,
  output logic                   done,
  output logic                   err,
  output logic [CNT_W-1:0]       prog_count,
  output prog_state_t            dbg_state
);

  localparam int T_MAX = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
  localparam int TW    = (T_MAX > 1) ? $clog2(T_MAX) : 1;
  localparam logic [TW-1:0] PULSE_LD = TW'(PULSE_CYCLES - 1);
  localparam logic [TW-1:0] GAP_LD   = TW'(GAP_CYCLES - 1);

  prog_state_t            state;
  logic [TW-1:0]          cnt;
  logic [ADDR_W-1:0]      addr_q;
  logic                   data_q;
  logic                   addr_ok;
  logic [ADDR_W-1:0]      dec_addr;
  logic                   dec_data;
  logic                   dec_en;
  local_lines_t           loc;
  logic [3*NUM_CELLS-1:0] dec_bl;
  logic [3*NUM_CELLS-1:0] dec_wl;

  // Handshake: a command transfers on a rising edge where cmd_valid and
  // cmd_ready are both high; cmd_ready is high only in IDLE, so a command
  // offered while busy simply waits with cmd_valid held.
  assign addr_ok   = int'(cmd_addr) < NUM_CELLS;
  assign dbg_state = state;

  // Lines are loaded on the edge that enters a pulse state, so the decoder
  // looks at the incoming command in IDLE and at the latched one in PH0_GAP.
  always_comb begin
    dec_addr = (state == IDLE) ? cmd_addr : addr_q;
    dec_data = (state == IDLE) ? cmd_data : data_q;
    dec_en   = ((state == IDLE) && cmd_valid && addr_ok) || (state == PH0_GAP);
    loc      = phase_lines(dec_data, state == PH0_GAP);
  end

  rram_prog_line_dec #(
    .NUM_CELLS(NUM_CELLS),
    .ADDR_W   (ADDR_W)
  ) u_line_dec (
    .en    (dec_en),
    .addr  (dec_addr),
    .bl_loc(loc.bl),
    .wl_loc(loc.wl),
    .bl    (dec_bl),
    .wl    (dec_wl)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      addr_q     <= '0;
      data_q     <= 1'b0;
      bl         <= '0;
      wl         <= '0;
      done       <= 1'b0;
      err        <= 1'b0;
      cmd_ready  <= 1'b1;
      prog_count <= '0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            addr_q    <= cmd_addr;
            data_q    <= cmd_data;
            cmd_ready <= 1'b0;
            if (addr_ok) begin
              state <= PH0_ON;
              cnt   <= PULSE_LD;
              bl    <= dec_bl;
              wl    <= dec_wl;
            end else begin
              state <= ERR;
              cnt   <= '0;
              err   <= 1'b1;
            end
          end
        end
        PH0_ON: begin
          if (cnt == '0) begin
            state <= PH0_GAP;
            cnt   <= GAP_LD;
            bl    <= '0;
            wl    <= '0;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        PH0_GAP: begin
          if (cnt == '0) begin
            state <= PH1_ON;
            cnt   <= PULSE_LD;
            bl    <= dec_bl;
            wl    <= dec_wl;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        PH1_ON: begin
          if (cnt == '0) begin
            state <= PH1_GAP;
            cnt   <= GAP_LD;
            bl    <= '0;
            wl    <= '0;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        PH1_GAP: begin
          if (cnt == '0) begin
            state     <= IDLE;
            cnt       <= '0;
            done      <= 1'b1;
            cmd_ready <= 1'b1;
            if (prog_count != '1) prog_count <= prog_count + 1'b1;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ERR: begin
          state     <= IDLE;
          cnt       <= '0;
          cmd_ready <= 1'b1;
        end
        default: begin
          state     <= IDLE;
          cnt       <= '0;
          bl        <= '0;
          wl        <= '0;
          cmd_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: doc/rram_prog_ctrl.md
# rram_prog_ctrl

Sequencer that programs an array of 2-RRAM configuration cells (`sram6T_rram`-style, three BL and three WL inputs per cell) through their bit-line/word-line ports. It accepts single-bit program commands over a valid/ready handshake. For each command it drives the two timed BL/WL pulse phases needed to place the cell's RRAM pair in the complementary state for the requested value. It sits between the configuration loader and the configuration-memory array. Only one cell's lines are ever active at a time.

## Interface
- `NUM_CELLS`, 8: number of cells driven. Minimum 1.
- `ADDR_W`, 3: cell address width. Must satisfy 2^ADDR_W >= NUM_CELLS.
- `PULSE_CYCLES`, 4: clock cycles each programming pulse is held. Minimum 1.
- `GAP_CYCLES`, 2: all-lines-low cycles after each pulse. Minimum 1.
- `CNT_W`, 16: width of the completed-program counter.

- `clk`, input, 1: clock; all state changes on rising edge.
- `rst`, input, 1: reset, synchronous, active-high.
- `cmd_valid`, input, 1: command present.
- `cmd_ready`, output, 1: controller can accept a command.
- `cmd_addr`, input, ADDR_W: target cell index.
- `cmd_data`, input, 1: value to program; it becomes the cell's dout.
- `bl`, output, 3*NUM_CELLS: bit lines. Cell i local line k is `bl[3*i+k]`, LSB-first.
- `wl`, output, 3*NUM_CELLS: word lines, same mapping as `bl`.
- `done`, output, 1: one-cycle pulse when a valid command completes.
- `err`, output, 1: one-cycle pulse when a command addresses a cell >= NUM_CELLS.
- `prog_count`, output, CNT_W: number of completed programs, saturating.

## Operation
- Cell model, local lines per cell: r0 is set to 1 by bl[2]&wl[0] and cleared to 0 by bl[0]&wl[2]. r1 is set to 1 by bl[2]&wl[1] and cleared to 0 by bl[1]&wl[2]. Cell dout = r0 | ~r1.
- Programming `cmd_data`=1:
  - PH0 drives local bl[2], wl[0], setting r0=1.
  - PH1 drives local bl[1], wl[2], clearing r1=0.
- Programming `cmd_data`=0:
  - PH0 drives local bl[0], wl[2], clearing r0=0.
  - PH1 drives local bl[2], wl[1], setting r1=1.
- During a pulse, exactly one BL bit and one WL bit of the addressed cell are high. All other bits are 0.
- FSM states: IDLE, PH0_ON, PH0_GAP, PH1_ON, PH1_GAP, ERR.
  - IDLE: `cmd_ready`=1. On `cmd_valid`, latch addr and data. Go to ERR if addr >= NUM_CELLS, otherwise go to PH0_ON.
  - PH0_ON holds for PULSE_CYCLES, then PH0_GAP.
  - PH0_GAP holds for GAP_CYCLES, then PH1_ON.
  - PH1_ON holds for PULSE_CYCLES, then PH1_GAP.
  - PH1_GAP holds for GAP_CYCLES, then IDLE with `done`=1.
  - ERR lasts one cycle with `err`=1, then IDLE.
- The cycle counter reloads on every state entry.
- `prog_count` increments on each `done` and saturates at all-ones. It is not incremented on `err`.
- `cmd_ready`=0 in every state except IDLE. Commands presented while busy are held off, not dropped.
- Outputs `bl`, `wl`, `done`, `err`, `cmd_ready` are registered (no combinational path from `cmd_*`).

## Timing
- Reset values:
  - state IDLE
  - `bl`=0, `wl`=0
  - `done`=0, `err`=0
  - `prog_count`=0
  - `cmd_ready`=1 from the first cycle after reset release
- Reset asserted mid-operation: all lines drop to 0 at the next edge. The partial command is abandoned, with no `done` and no count.
- Command accepted at edge k (`cmd_valid`&`cmd_ready`). With P=PULSE_CYCLES and G=GAP_CYCLES:
  - PH0 lines high for cycles k+1..k+P.
  - Lines low for cycles k+P+1..k+P+G.
  - PH1 lines high for cycles k+P+G+1..k+2P+G.
  - Lines low for cycles k+2P+G+1..k+2P+2G.
  - Cycle k+2P+2G+1: `done`=1, `cmd_ready`=1, `prog_count` already incremented.
- Back-to-back: a command valid in the `done` cycle is accepted at that edge. Minimum command period is 2P+2G+1 cycles.
- Error command at edge k: `err`=1 and `cmd_ready`=0 in cycle k+1. `cmd_ready`=1 in cycle k+2. No line activity.
- PH0 and PH1 lines never overlap. There are at least G low cycles between any two pulses, including across commands.

## Structure
- Package `rram_prog_pkg`:
  - FSM state enum.
  - Local line index constants (BL_R0_CLR=0, BL_R1_CLR=1, BL_SET=2; WL_R0_SET=0, WL_R1_SET=1, WL_CLR=2).
  - Function mapping (data, phase) to a 3-bit local BL one-hot and a 3-bit local WL one-hot.
- Sub-module `rram_prog_line_dec` (combinational): places the local one-hots at cell `addr`, zero elsewhere, and takes an enable. The controller registers its outputs.

## Test plan
Bench parameters: NUM_CELLS=4, P=2, G=1.
- Reset, then idle: `bl`=`wl`=0, `cmd_ready`=1, `prog_count`=0.
- Program addr=2, data=1, accepted at edge k:
  - `bl[8]`&`wl[6]` high for cycles k+1..k+2.
  - All lines low at k+3.
  - `bl[7]`&`wl[8]` high at k+4..k+5.
  - `done` at k+7.
  - Behavioural cell 2 dout=1, `prog_count`=1.
- Program addr=0, data=0, with `cmd_valid` held over from the prior `done` cycle:
  - Accepted immediately.
  - `bl[0]`&`wl[2]` pulse, then `bl[2]`&`wl[1]` pulse.
  - Cell 0 dout=0.
- addr=5 → `err`=1 one cycle after accept, no line toggles, `prog_count` unchanged. Next command is accepted 2 cycles after.
- Assert `rst` during PH1_ON → lines 0 next cycle, no `done`, `cmd_ready`=1 after release.
- Force `prog_count` to all-ones (CNT_W=2 build), then complete one program → count stays 3.
